tile_rasterizer_lanes: RTL and testbench
========================================

Name: tile_rasterizer_lanes

Overview:
- Parametrised successor to the single-pixel tile edge-function rasterizer.
- Walks one tile of 2^TILE_W_LOG2 x 2^TILE_H_LOG2 pixels under its own scan FSM.
- Evaluates three incremental edge functions for LANES horizontally adjacent pixels per cycle.
- Emits per-group coverage masks over a valid/ready stream; supports clear mode and optional skipping of empty groups.

Parameters:
- TILE_W_LOG2, 5, log2 of tile width in pixels.
- TILE_H_LOG2, 5, log2 of tile height in pixels.
- LANES, 4, pixels per output beat; power of 2, at most 2^TILE_W_LOG2.
- A_W, 19, width of the signed per-pixel x-step inputs.
- B_W, 24, width of the signed per-row y-step inputs.
- W_W, 32, width of the signed edge-value accumulators.
- SKIP_EMPTY, 1, 1 = suppress raster-mode beats whose mask is all zero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin tile; accepted only when busy=0.
- clear  in  1  mode sampled at start: 1 = clear (full masks), 0 = raster.
- A01, A12, A20  in  A_W each  signed x-steps for the three edges.
- B01, B12, B20  in  B_W each  signed y-steps for the three edges.
- w0_in, w1_in, w2_in  in  W_W each  edge values at pixel (0,0); w2 goes to edge01, w0 to edge12, w1 to edge20.
- busy  out  1  tile in progress.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_x  out  TILE_W_LOG2  x of lane 0 (multiple of LANES).
- out_y  out  TILE_H_LOG2  row.
- out_mask  out  LANES  bit k = pixel (out_x+k, out_y) covered.
- out_clear  out  1  latched mode for this beat.
- done  out  1  one-cycle pulse when the tile completes.

Behaviour:
- Arithmetic:
  - A and B are sign-extended to W_W bits; all sums wrap modulo 2^W_W. The caller guarantees no overflow.
  - Edge value: e(x,y) = w + x*A + y*B.
  - A pixel is inside iff all three e >= 0 (sign bits clear).
- State registers: per edge, row_base and cursor. Lane k value = cursor + k*A (constant-multiple adders, combinational).
- Mask:
  - out_mask = all ones in clear mode, otherwise the inside bits.
  - out_mask is combinational from registered state only, and holds stable while out_valid && !out_ready.
- FSM IDLE:
  - busy=0, out_valid=0.
  - On start, latch all A, B, w and clear; set row_base = cursor = w; x=0, y=0; go to RUN.
  - out_valid=1 for the first beat in the next cycle (1-cycle latency).
- FSM RUN:
  - A group advances on handshake (out_valid && out_ready), or on a skip cycle.
  - Skip cycle: SKIP_EMPTY=1, raster mode, mask==0. During a skip, out_valid=0 for that cycle.
  - Advance within a row: x += LANES, cursor += LANES*A.
  - Advance at the last group of a row (x = 2^TILE_W_LOG2 - LANES): x=0, y++, row_base += B, cursor = row_base + B.
  - Advance at the last group of the last row: go to IDLE; done=1 in the following cycle; busy=0 in that same cycle.
- start while busy is ignored. Latched inputs do not change mid-tile, whatever the input ports do.
- Clear mode never skips.
- Beat count:
  - Full tile: 2^(TILE_W_LOG2+TILE_H_LOG2)/LANES beats.
  - Worst case: the same number of cycles with out_ready=1.
- Reset:
  - Values after reset: busy=0, out_valid=0, done=0, out_x=0, out_y=0, out_clear=0, state IDLE.
  - Reset mid-tile abandons the tile with no done pulse.
  - start in the first cycle after reset deasserts is honoured.

Test Plan:
- Defaults, clear=1, out_ready=1: start -> busy next cycle, 256 beats with out_mask=4'hF, out_x 0,4,...,28 per row, out_y 0..31; done one cycle after beat 256.
- Raster, all A=B=0, w0=w1=w2=1 -> 256 full masks. Then w0_in=-1, SKIP_EMPTY=1 -> zero beats and done 256 cycles after start.
- Raster, A01=-1, B01=0, w2_in=14, other edges A=B=0 and w=1 -> each row: x=12 mask 4'b0111, x=0..8 mask 4'hF, x>=16 mask 0 (skipped); 4 beats per row.
- Raster, B12=-1, A12=0, w0_in=3, others full -> rows 0..3 full, rows 4..31 skipped; done at cycle 256.
- Backpressure: drop out_ready for 10 cycles at beat 5 -> out_x, out_y, out_mask stable; total beat count unchanged; no duplicate beats.
- start pulsed mid-tile has no effect. rst at beat 100 -> next cycle busy=0, out_valid=0, no done; a following start restarts at (0,0).

Source files
------------

// File: rtl/tile_rasterizer_lanes.sv
// Tile rasterizer that walks one tile in LANES-wide pixel groups and streams per-group
// coverage masks from three incremental edge functions.
module tile_rasterizer_lanes #(
  parameter int unsigned TILE_W_LOG2 = 5,
  parameter int unsigned TILE_H_LOG2 = 5,
  parameter int unsigned LANES       = 4,
  parameter int unsigned A_W         = 19,
  parameter int unsigned B_W         = 24,
  parameter int unsigned W_W         = 32,
  parameter int unsigned SKIP_EMPTY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [A_W-1:0]         A01,
  input  logic [A_W-1:0]         A12,
  input  logic [A_W-1:0]         A20,
  input  logic [B_W-1:0]         B01,
  input  logic [B_W-1:0]         B12,
  input  logic [B_W-1:0]         B20,
  input  logic [W_W-1:0]         w0_in,
  input  logic [W_W-1:0]         w1_in,
  input  logic [W_W-1:0]         w2_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TILE_W_LOG2-1:0] out_x,
  output logic [TILE_H_LOG2-1:0] out_y,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_clear,
  output logic                   done
);

  localparam int unsigned TILE_W = 1 << TILE_W_LOG2;
  localparam int unsigned TILE_H = 1 << TILE_H_LOG2;
  localparam logic [TILE_W_LOG2-1:0] LAST_X = TILE_W_LOG2'(TILE_W - LANES);
  localparam logic [TILE_H_LOG2-1:0] LAST_Y = TILE_H_LOG2'(TILE_H - 1);
  localparam logic [TILE_W_LOG2-1:0] X_STEP = TILE_W_LOG2'(LANES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [TILE_W_LOG2-1:0] x_q, x_d;
  logic [TILE_H_LOG2-1:0] y_q, y_d;
  logic                   clear_q, clear_d;
  logic                   done_q, done_d;
  logic [2:0][W_W-1:0]    a_q, a_d, b_q, b_d, row_q, row_d, cur_q, cur_d;

  logic [LANES-1:0]       inside_c;
  logic [W_W-1:0]         lane_val_c;
  logic                   skip_c;
  logic                   advance_c;

  function automatic logic [W_W-1:0] sext_a(input logic [A_W-1:0] v);
    return W_W'(signed'(v));
  endfunction

  function automatic logic [W_W-1:0] sext_b(input logic [B_W-1:0] v);
    return W_W'(signed'(v));
  endfunction

  // Lane k sits k pixels right of the cursor; inside when no edge value is negative.
  always_comb begin
    inside_c   = '0;
    lane_val_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      inside_c[k] = 1'b1;
      for (int e = 0; e < 3; e++) begin
        lane_val_c = cur_q[e] + W_W'(k) * a_q[e];
        if (lane_val_c[W_W-1]) inside_c[k] = 1'b0;
      end
    end
  end

  assign out_mask  = clear_q ? '1 : inside_c;
  assign skip_c    = (state_q == S_RUN) && (SKIP_EMPTY != 0) && !clear_q && (inside_c == '0);
  assign out_valid = (state_q == S_RUN) && !skip_c;
  assign advance_c = (out_valid && out_ready) || skip_c;
  assign busy      = (state_q == S_RUN);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_clear = clear_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      cur_q   <= cur_d;
    end
  end

  // Scan FSM: latch the tile on start, then step groups left-to-right, rows top-to-bottom.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    clear_d = clear_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    row_d   = row_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = '0;
          clear_d = clear;
          a_d[0]  = sext_a(A01);
          a_d[1]  = sext_a(A12);
          a_d[2]  = sext_a(A20);
          b_d[0]  = sext_b(B01);
          b_d[1]  = sext_b(B12);
          b_d[2]  = sext_b(B20);
          row_d[0] = w2_in;
          row_d[1] = w0_in;
          row_d[2] = w1_in;
          cur_d    = row_d;
        end
      end
      S_RUN: begin
        if (advance_c) begin
          if (x_q == LAST_X) begin
            x_d = '0;
            if (y_q == LAST_Y) begin
              state_d = S_IDLE;
              y_d     = '0;
              done_d  = 1'b1;
            end else begin
              y_d = y_q + TILE_H_LOG2'(1);
              for (int e = 0; e < 3; e++) begin
                row_d[e] = row_q[e] + b_q[e];
                cur_d[e] = row_q[e] + b_q[e];
              end
            end
          end else begin
            x_d = x_q + X_STEP;
            for (int e = 0; e < 3; e++) cur_d[e] = cur_q[e] + W_W'(LANES) * a_q[e];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_rasterizer_lanes.sv
// Directed bench for tile_rasterizer_lanes: full tiles in clear/raster modes, skipping,
// backpressure, ignored mid-tile start and reset mid-tile.
module tb_tile_rasterizer_lanes;

  localparam int TWL = 5;
  localparam int THL = 5;
  localparam int LN  = 4;
  localparam int TW  = 1 << TWL;
  localparam int TH  = 1 << THL;

  logic           clk = 1'b0;
  logic           rst, start, clear, out_ready;
  logic [18:0]    A01, A12, A20;
  logic [23:0]    B01, B12, B20;
  logic [31:0]    w0_in, w1_in, w2_in;
  logic           busy, out_valid, out_clear, done;
  logic [TWL-1:0] out_x;
  logic [THL-1:0] out_y;
  logic [LN-1:0]  out_mask;

  longint ea[3], eb[3], ew[3];
  bit     mclr;
  int     n_cmp = 0;
  int     n_bad = 0;

  tile_rasterizer_lanes #(
    .TILE_W_LOG2(TWL), .TILE_H_LOG2(THL), .LANES(LN),
    .A_W(19), .B_W(24), .W_W(32), .SKIP_EMPTY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .A01(A01), .A12(A12), .A20(A20), .B01(B01), .B12(B12), .B20(B20),
    .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_mask(out_mask), .out_clear(out_clear), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edge order: 01 uses w2, 12 uses w0, 20 uses w1.
  task automatic set_tile(input bit clr, input int a01, input int a12, input int a20,
                          input int b01, input int b12, input int b20,
                          input int w0, input int w1, input int w2);
    clear = clr;
    A01 = 19'(a01); A12 = 19'(a12); A20 = 19'(a20);
    B01 = 24'(b01); B12 = 24'(b12); B20 = 24'(b20);
    w0_in = 32'(w0); w1_in = 32'(w1); w2_in = 32'(w2);
    mclr = clr;
    ea[0] = a01; eb[0] = b01; ew[0] = w2;
    ea[1] = a12; eb[1] = b12; ew[1] = w0;
    ea[2] = a20; eb[2] = b20; ew[2] = w1;
  endtask

  task automatic scramble();
    clear = ~clear;
    A01 = 19'($urandom); A12 = 19'($urandom); A20 = 19'($urandom);
    B01 = 24'($urandom); B12 = 24'($urandom); B20 = 24'($urandom);
    w0_in = $urandom; w1_in = $urandom; w2_in = $urandom;
  endtask

  function automatic logic [LN-1:0] model_mask(input int gx, input int gy);
    logic [LN-1:0] m;
    m = '0;
    if (mclr) return '1;
    for (int k = 0; k < LN; k++) begin
      m[k] = 1'b1;
      for (int e = 0; e < 3; e++)
        if (ew[e] + longint'(gx + k) * ea[e] + longint'(gy) * eb[e] < 0) m[k] = 1'b0;
    end
    return m;
  endfunction

  // Step to the next group that should appear on the stream (empty raster groups are skipped).
  task automatic next_grp(inout int gx, inout int gy, input bit first);
    if (!first) begin
      gx += LN;
      if (gx == TW) begin gx = 0; gy++; end
    end
    while (gy < TH && !mclr && model_mask(gx, gy) == '0) begin
      gx += LN;
      if (gx == TW) begin gx = 0; gy++; end
    end
  endtask

  task automatic run_tile(input string name, input int exp_beats, input int exp_done,
                          input bit bp, input bit mid_start, input int abort_at);
    int cyc, beats, hold, gx, gy;
    bit fin, aborted;
    cyc = 1; beats = 0; hold = 0; gx = 0; gy = 0; fin = 0; aborted = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    check({name, "/busy_after_start"}, 64'(busy), 64'd1);
    next_grp(gx, gy, 1'b1);
    while (!fin && !aborted && cyc < 2000) begin
      out_ready = !(bp && beats == 5 && hold < 10);
      if (!out_ready) hold++;
      start = mid_start && (cyc == 50);
      if (done) begin
        fin = 1'b1;
        check({name, "/done_cycle"}, 64'(cyc), 64'(exp_done));
        check({name, "/beats"}, 64'(beats), 64'(exp_beats));
        check({name, "/busy_at_done"}, 64'({busy, out_valid}), 64'd0);
      end else if (out_valid) begin
        check({name, "/beat"}, 64'({out_clear, out_y, out_x, out_mask}),
              64'({mclr, THL'(gy), TWL'(gx), model_mask(gx, gy)}));
        if (out_ready) begin
          beats++;
          next_grp(gx, gy, 1'b0);
          if (abort_at != 0 && beats == abort_at) begin
            aborted = 1'b1;
            rst = 1'b1;
          end
        end
      end
      if (!fin && !aborted) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      check({name, "/after_reset"}, 64'({busy, out_valid, done, out_x, out_y}), 64'd0);
    end else if (!fin) begin
      check({name, "/timeout"}, 64'(fin), 64'd1);
    end else begin
      @(posedge clk); #1;
      check({name, "/done_pulse"}, 64'({done, busy}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_tile(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({busy, out_valid, done, out_x, out_y, out_clear}), 64'd0);
    rst = 1'b0;

    // Clear mode, start in the first cycle after reset, ignored start at cycle 50.
    set_tile(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tile("clear", 256, 257, 1'b0, 1'b1, 0);

    set_tile(1'b0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    run_tile("raster_full", 256, 257, 1'b0, 1'b0, 0);

    set_tile(1'b0, 0, 0, 0, 0, 0, 0, -1, 1, 1);
    run_tile("raster_empty", 0, 257, 1'b0, 1'b0, 0);

    // Edge01 = 14 - x: groups 0..8 full, 12 -> 4'b0111, 16+ skipped.
    set_tile(1'b0, -1, 0, 0, 0, 0, 0, 1, 1, 14);
    run_tile("vert_edge", 128, 257, 1'b0, 1'b0, 0);

    // Edge12 = 3 - y: rows 0..3 full, rest skipped.
    set_tile(1'b0, 0, 0, 0, 0, -1, 0, 3, 1, 1);
    run_tile("horz_edge", 32, 257, 1'b0, 1'b0, 0);

    set_tile(1'b0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    run_tile("backpressure", 256, 267, 1'b1, 1'b0, 0);

    set_tile(1'b0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    run_tile("abort", 0, 0, 1'b0, 1'b0, 100);
    set_tile(1'b0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    run_tile("restart", 256, 257, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
